// File: rtl/isq_pkg.sv
// rtl/isq_pkg.sv - shared issue-queue widths, ROB state encoding and flush/wakeup helpers
package isq_pkg;

   localparam int ISQ_DATA_WIDTH      = 248;
   localparam int ISQ_CONDITION_WIDTH = 2;
   localparam int ROB_SIZE_LOG        = 6;

   typedef enum logic [1:0] {
      ROB_STATE_IDLE     = 2'd0,
      ROB_STATE_NORMAL   = 2'd1,
      ROB_STATE_ROLLBACK = 2'd2,
      ROB_STATE_BLOCKED  = 2'd3
   } rob_state_t;

   // robid carries a wrap bit above the index, so age compares across one wrap of the ROB.
   function automatic logic robid_is_younger(input logic [ROB_SIZE_LOG:0] flush_robid,
                                             input logic [ROB_SIZE_LOG:0] robid);
      return flush_robid[ROB_SIZE_LOG] ^ robid[ROB_SIZE_LOG] ^
             (flush_robid[ROB_SIZE_LOG-1:0] < robid[ROB_SIZE_LOG-1:0]);
   endfunction

   // Overwrite only the masked condition bits with the broadcast values.
   function automatic logic [ISQ_CONDITION_WIDTH-1:0] cond_merge(
      input logic [ISQ_CONDITION_WIDTH-1:0] cond,
      input logic [ISQ_CONDITION_WIDTH-1:0] mask,
      input logic [ISQ_CONDITION_WIDTH-1:0] upd_in);
      return (cond & ~mask) | (upd_in & mask);
   endfunction

endpackage

// File: rtl/isq_stage_entry.sv
// rtl/isq_stage_entry.sv - one staging slot: payload, condition and valid, snooping condition updates
module isq_stage_entry
   import isq_pkg::*;
#(
   parameter int DATA_WIDTH  = ISQ_DATA_WIDTH,
   parameter int COND_WIDTH  = ISQ_CONDITION_WIDTH,
   parameter int ROBID_WIDTH = ROB_SIZE_LOG + 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   write_en,
   input  logic [DATA_WIDTH-1:0]  write_data,
   input  logic [COND_WIDTH-1:0]  write_cond,
   input  logic                   clear,
   input  logic                   update_valid,
   input  logic [ROBID_WIDTH-1:0] update_robid,
   input  logic [COND_WIDTH-1:0]  update_mask,
   input  logic [COND_WIDTH-1:0]  update_in,
   output logic                   valid,
   output logic [DATA_WIDTH-1:0]  data,
   output logic [COND_WIDTH-1:0]  cond
);

   logic write_hit;
   logic hold_hit;

   assign write_hit = update_valid && (write_data[DATA_WIDTH-1 -: ROBID_WIDTH] == update_robid);
   assign hold_hit  = update_valid && (data[DATA_WIDTH-1 -: ROBID_WIDTH] == update_robid);

   // Capture a new micro-op (merging a same-cycle wakeup), or snoop wakeups while resident.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid <= 1'b0;
      end else if (write_en) begin
         valid <= 1'b1;
         data  <= write_data;
         cond  <= write_hit ? cond_merge(write_cond, update_mask, update_in) : write_cond;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (valid && hold_hit) begin
         cond  <= cond_merge(cond, update_mask, update_in);
      end
   end

endmodule

// File: rtl/isq_enq_stager.sv
// rtl/isq_enq_stager.sv - dual-lane dispatch staging FIFO draining into a single-port issue queue; ISQ_ENQ_BYPASS_EN adds an empty-FIFO lane0 bypass
module isq_enq_stager
   import isq_pkg::*;
#(
   parameter int DATA_WIDTH  = ISQ_DATA_WIDTH,
   parameter int COND_WIDTH  = ISQ_CONDITION_WIDTH,
   parameter int ROBID_WIDTH = ROB_SIZE_LOG + 1,
   parameter int DEPTH       = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       disp_valid0,
   input  logic [DATA_WIDTH-1:0]      disp_data0,
   input  logic [COND_WIDTH-1:0]      disp_cond0,
   input  logic                       disp_valid1,
   input  logic [DATA_WIDTH-1:0]      disp_data1,
   input  logic [COND_WIDTH-1:0]      disp_cond1,
   output logic                       disp_ready,
   output logic                       enq_valid,
   output logic [DATA_WIDTH-1:0]      enq_data,
   output logic [COND_WIDTH-1:0]      enq_condition,
   input  logic                       enq_ready,
   input  logic                       update_valid,
   input  logic [ROBID_WIDTH-1:0]     update_robid,
   input  logic [COND_WIDTH-1:0]      update_mask,
   input  logic [COND_WIDTH-1:0]      update_in,
   input  logic [1:0]                 rob_state,
   input  logic                       flush_valid,
   input  logic [ROBID_WIDTH-1:0]     flush_robid,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int RMSB  = DATA_WIDTH - 1;

   logic [PTR_W-1:0]      head, tail, slot1;
   logic [CNT_W-1:0]      count, keep, pushes;
   logic [DEPTH-1:0]      ent_valid, wr_en, clr;
   logic [DATA_WIDTH-1:0] ent_data [DEPTH];
   logic [COND_WIDTH-1:0] ent_cond [DEPTH];
   logic [DATA_WIDTH-1:0] wr_data  [DEPTH];
   logic [COND_WIDTH-1:0] wr_cond  [DEPTH];

   logic flush_hit, bypass_sel, bypass_pop, pop_fifo;
   logic accept0, accept1, write0, write1;
   logic head_hit, lane0_hit;
   logic [COND_WIDTH-1:0] head_cond_m, lane0_cond_m;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_entry
         isq_stage_entry #(
            .DATA_WIDTH  (DATA_WIDTH),
            .COND_WIDTH  (COND_WIDTH),
            .ROBID_WIDTH (ROBID_WIDTH)
         ) u_entry (
            .clock        (clock),
            .reset_n      (reset_n),
            .write_en     (wr_en[g]),
            .write_data   (wr_data[g]),
            .write_cond   (wr_cond[g]),
            .clear        (clr[g]),
            .update_valid (update_valid),
            .update_robid (update_robid),
            .update_mask  (update_mask),
            .update_in    (update_in),
            .valid        (ent_valid[g]),
            .data         (ent_data[g]),
            .cond         (ent_cond[g])
         );
      end
   endgenerate

   assign flush_hit  = flush_valid && (rob_state == ROB_STATE_ROLLBACK);
   assign disp_ready = ((DEPTH - int'(count)) >= 2) && !flush_valid;
   assign occupancy  = count;

`ifdef ISQ_ENQ_BYPASS_EN
   assign bypass_sel = (count == '0) && !flush_valid && disp_valid0;
`else
   assign bypass_sel = 1'b0;
`endif

   assign head_hit     = update_valid && (ent_data[head][RMSB -: ROBID_WIDTH] == update_robid);
   assign lane0_hit    = update_valid && (disp_data0[RMSB -: ROBID_WIDTH] == update_robid);
   assign head_cond_m  = head_hit  ? cond_merge(ent_cond[head], update_mask, update_in) : ent_cond[head];
   assign lane0_cond_m = lane0_hit ? cond_merge(disp_cond0, update_mask, update_in) : disp_cond0;

   assign enq_valid     = bypass_sel || (ent_valid[head] && !flush_valid);
   assign enq_data      = bypass_sel ? disp_data0   : ent_data[head];
   assign enq_condition = bypass_sel ? lane0_cond_m : head_cond_m;

   assign bypass_pop = bypass_sel && enq_ready;
   assign pop_fifo   = enq_valid && enq_ready && !bypass_sel;

   // Lane1 is only legal behind lane0; a lone lane1 is dropped.
   assign accept0 = disp_valid0 && disp_ready;
   assign accept1 = disp_valid1 && disp_valid0 && disp_ready;
   assign write0  = accept0 && !bypass_pop;
   assign write1  = accept1;
   assign pushes  = CNT_W'(write0) + CNT_W'(write1);
   assign slot1   = write0 ? PTR_W'(tail + PTR_W'(1)) : tail;

   // Find the first entry (from head) younger than the flush robid; the FIFO is age-ordered.
   always_comb begin
      logic found;
      logic [PTR_W-1:0] s;
      found = 1'b0;
      keep  = count;
      for (int k = 0; k < DEPTH; k++) begin
         s = PTR_W'(head + PTR_W'(k));
         if (!found && (k < int'(count)) &&
             robid_is_younger(flush_robid, ent_data[s][RMSB -: ROBID_WIDTH])) begin
            found = 1'b1;
            keep  = CNT_W'(k);
         end
      end
   end

   // Steer lane writes to tail slots and clear popped or squashed slots.
   always_comb begin
      logic [PTR_W-1:0] off;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en[i]   = 1'b0;
         wr_data[i] = disp_data0;
         wr_cond[i] = disp_cond0;
         clr[i]     = 1'b0;
         off        = PTR_W'(PTR_W'(i) - head);
         if (write0 && (tail == PTR_W'(i))) begin
            wr_en[i] = 1'b1;
         end else if (write1 && (slot1 == PTR_W'(i))) begin
            wr_en[i]   = 1'b1;
            wr_data[i] = disp_data1;
            wr_cond[i] = disp_cond1;
         end
         if (pop_fifo && (off == '0))
            clr[i] = 1'b1;
         if (flush_hit && (int'(off) >= int'(keep)) && (int'(off) < int'(count)))
            clr[i] = 1'b1;
      end
   end

   // Pointer and count update; a rollback rewinds tail to the first squashed entry.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_hit) begin
         tail  <= PTR_W'(head + PTR_W'(keep));
         count <= keep;
      end else begin
         head  <= PTR_W'(head + PTR_W'(pop_fifo));
         tail  <= PTR_W'(tail + PTR_W'(pushes));
         count <= count + pushes - CNT_W'(pop_fifo);
      end
   end

   lane_order_a: assert property (@(posedge clock) disable iff (!reset_n)
                                  !(disp_valid1 && !disp_valid0));

endmodule

// File: tb/tb_isq_enq_stager.sv
// tb/tb_isq_enq_stager.sv - scoreboard bench for isq_enq_stager (default build, ISQ_ENQ_BYPASS_EN undefined)
module tb_isq_enq_stager;
   import isq_pkg::*;

   localparam int DW = 248;
   localparam int CW = 2;
   localparam int RW = 7;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [RW-1:0] robid;
      logic [CW-1:0] cond;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          disp_valid0, disp_valid1;
   logic [DW-1:0] disp_data0, disp_data1;
   logic [CW-1:0] disp_cond0, disp_cond1;
   logic          disp_ready;
   logic          enq_valid;
   logic [DW-1:0] enq_data;
   logic [CW-1:0] enq_condition;
   logic          enq_ready;
   logic          update_valid;
   logic [RW-1:0] update_robid;
   logic [CW-1:0] update_mask, update_in;
   logic [1:0]    rob_state;
   logic          flush_valid;
   logic [RW-1:0] flush_robid;
   logic [2:0]    occupancy;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   isq_enq_stager #(.DATA_WIDTH(DW), .COND_WIDTH(CW), .ROBID_WIDTH(RW), .DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .disp_valid0   (disp_valid0),
      .disp_data0    (disp_data0),
      .disp_cond0    (disp_cond0),
      .disp_valid1   (disp_valid1),
      .disp_data1    (disp_data1),
      .disp_cond1    (disp_cond1),
      .disp_ready    (disp_ready),
      .enq_valid     (enq_valid),
      .enq_data      (enq_data),
      .enq_condition (enq_condition),
      .enq_ready     (enq_ready),
      .update_valid  (update_valid),
      .update_robid  (update_robid),
      .update_mask   (update_mask),
      .update_in     (update_in),
      .rob_state     (rob_state),
      .flush_valid   (flush_valid),
      .flush_robid   (flush_robid),
      .occupancy     (occupancy)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] mk(input logic [RW-1:0] r);
      logic [DW-1:0] d;
      d = '0;
      d[DW-1 -: RW] = r;
      d[31:0] = {24'hC0FFEE, 1'b0, r};
      d[100 +: 8] = {1'b1, r};
      return d;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [RW-1:0] r0, input logic [CW-1:0] c0,
                        input logic v1, input logic [RW-1:0] r1, input logic [CW-1:0] c1);
      disp_valid0 = v0; disp_data0 = mk(r0); disp_cond0 = c0;
      disp_valid1 = v1; disp_data1 = mk(r1); disp_cond1 = c1;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      update_valid = 1'b0;
      flush_valid  = 1'b0;
      rob_state    = ROB_STATE_NORMAL;
   endtask

   task automatic drain(input int n);
      enq_ready = 1'b1;
      repeat (n) cyc();
      enq_ready = 1'b0;
   endtask

   // Monitor: every accepted enqueue must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && enq_valid && enq_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_enq: got robid %0h expected none", enq_data[DW-1 -: RW]);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("enq_data", 64'(enq_data[DW-1 -: RW] ^ RW'(enq_data != mk(e.robid))), 64'(e.robid));
               chk("enq_condition", 64'(enq_condition), 64'(e.cond));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int mcount, pushed, n, pop;
      reset_n = 1'b0;
      enq_ready = 1'b0;
      update_robid = '0; update_mask = '0; update_in = '0; flush_robid = '0;
      idle();
      repeat (3) cyc();
      reset_n = 1'b1;

      // Reset state, then a two-lane burst with enq_ready high.
      enq_ready = 1'b1;
      drive(1'b1, 7'h01, 2'b00, 1'b1, 7'h02, 2'b00);
      exp_q.push_back('{7'h01, 2'b00});
      exp_q.push_back('{7'h02, 2'b00});
      @(negedge clock);
      chk("reset_enq_valid", 64'(enq_valid), 0);
      chk("reset_occupancy", 64'(occupancy), 0);
      chk("reset_disp_ready", 64'(disp_ready), 1);
      cyc(); idle();
      @(negedge clock); chk("burst_occ2", 64'(occupancy), 2);
      chk("burst_valid", 64'(enq_valid), 1);
      cyc(); @(negedge clock); chk("burst_occ1", 64'(occupancy), 1);
      cyc(); @(negedge clock); chk("burst_occ0", 64'(occupancy), 0);

      // Full backpressure.
      cyc(); enq_ready = 1'b0;
      drive(1'b1, 7'h03, 2'b01, 1'b1, 7'h04, 2'b10);
      exp_q.push_back('{7'h03, 2'b01});
      exp_q.push_back('{7'h04, 2'b10});
      cyc();
      drive(1'b1, 7'h05, 2'b11, 1'b1, 7'h06, 2'b00);
      exp_q.push_back('{7'h05, 2'b11});
      exp_q.push_back('{7'h06, 2'b00});
      @(negedge clock); chk("bp_ready_at2", 64'(disp_ready), 1);
      cyc(); idle();
      @(negedge clock); chk("bp_full_occ", 64'(occupancy), 4);
      chk("bp_full_ready", 64'(disp_ready), 0);
      cyc(); enq_ready = 1'b1;
      cyc(); enq_ready = 1'b0;
      @(negedge clock); chk("bp_occ3", 64'(occupancy), 3);
      chk("bp_ready_at3", 64'(disp_ready), 0);
      cyc(); enq_ready = 1'b1;
      cyc(); enq_ready = 1'b0;
      @(negedge clock); chk("bp_occ2", 64'(occupancy), 2);
      chk("bp_ready_again", 64'(disp_ready), 1);
      cyc(); drain(2);
      @(negedge clock); chk("bp_drained", 64'(occupancy), 0);

      // Same-cycle wakeup on the head and wakeup merged at write.
      cyc();
      drive(1'b1, 7'h05, 2'b00, 1'b0, '0, '0);
      exp_q.push_back('{7'h05, 2'b01});
      cyc(); idle();
      update_valid = 1'b1; update_robid = 7'h05; update_mask = 2'b01; update_in = 2'b01;
      @(negedge clock); chk("wake_same_cycle", 64'(enq_condition), 64'(2'b01));
      chk("wake_valid", 64'(enq_valid), 1);
      cyc();
      update_valid = 1'b1; update_robid = 7'h07; update_mask = 2'b01; update_in = 2'b01;
      drive(1'b1, 7'h07, 2'b10, 1'b0, '0, '0);
      exp_q.push_back('{7'h07, 2'b11});
      @(negedge clock); chk("wake_stored", 64'(enq_condition), 64'(2'b01));
      cyc(); idle();
      drain(2);
      @(negedge clock); chk("wake_drained", 64'(occupancy), 0);

      // Rollback across the wrap bit: 0x40/0x41 are younger than 0x3F.
      cyc();
      drive(1'b1, 7'h3E, 2'b00, 1'b1, 7'h3F, 2'b01);
      exp_q.push_back('{7'h3E, 2'b00});
      exp_q.push_back('{7'h3F, 2'b01});
      cyc();
      drive(1'b1, 7'h40, 2'b10, 1'b1, 7'h41, 2'b11);
      cyc(); idle();
      flush_valid = 1'b1; flush_robid = 7'h3F; rob_state = ROB_STATE_ROLLBACK; enq_ready = 1'b1;
      @(negedge clock); chk("rb_enq_blocked", 64'(enq_valid), 0);
      chk("rb_ready_blocked", 64'(disp_ready), 0);
      chk("rb_occ_before", 64'(occupancy), 4);
      cyc(); idle(); enq_ready = 1'b0;
      drive(1'b1, 7'h50, 2'b10, 1'b0, '0, '0);
      exp_q.push_back('{7'h50, 2'b10});
      @(negedge clock); chk("rb_occ_after", 64'(occupancy), 2);
      cyc(); idle();
      @(negedge clock); chk("rb_occ_refill", 64'(occupancy), 3);
      cyc(); drain(3);
      @(negedge clock); chk("rb_drained", 64'(occupancy), 0);

      // Flush outside rollback: no squash, but push and pop are blocked.
      cyc();
      drive(1'b1, 7'h10, 2'b01, 1'b1, 7'h11, 2'b10);
      exp_q.push_back('{7'h10, 2'b01});
      exp_q.push_back('{7'h11, 2'b10});
      cyc(); idle();
      flush_valid = 1'b1; flush_robid = 7'h10; rob_state = ROB_STATE_NORMAL; enq_ready = 1'b1;
      @(negedge clock); chk("nf_ready", 64'(disp_ready), 0);
      chk("nf_enq_valid", 64'(enq_valid), 0);
      cyc(); idle();
      @(negedge clock); chk("nf_occ", 64'(occupancy), 2);
      cyc();
      @(negedge clock); chk("nf_occ_after_pop", 64'(occupancy), 1);
      cyc(); enq_ready = 1'b0;
      @(negedge clock); chk("nf_drained", 64'(occupancy), 0);

      // Wrap-around: 20 pushes against random backpressure, order via scoreboard.
      cyc();
      mcount = 0; pushed = 0;
      for (int c = 0; c < 300 && pushed < 20; c++) begin
         enq_ready = 1'($urandom_range(0, 1));
         n = 0;
         if (DEPTH - mcount >= 2) begin
            n = $urandom_range(0, 2);
            if (pushed + n > 20) n = 20 - pushed;
         end
         drive(n > 0, 7'(7'h60 + pushed), 2'(pushed), n > 1, 7'(7'h61 + pushed), 2'(pushed + 1));
         for (int j = 0; j < n; j++) exp_q.push_back('{7'(7'h60 + pushed + j), 2'(pushed + j)});
         pushed += n;
         @(negedge clock);
         chk("wrap_occ", 64'(occupancy), 64'(mcount));
         chk("wrap_ready", 64'(disp_ready), 64'(DEPTH - mcount >= 2));
         pop = (mcount > 0 && enq_ready) ? 1 : 0;
         mcount = mcount + n - pop;
         cyc();
      end
      idle();
      enq_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
      enq_ready = 1'b0;
      repeat (2) cyc();
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      chk("final_occ", 64'(occupancy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
